shift_seq_ctrl: RTL

Multi-cycle shift sequencer for the CO datapath. It accepts a 32-bit operand, a shift amount and a shift type, then drives an internal 1-bit shift stage for up to 31 cycles. It returns the result with a one-cycle done pulse. It replaces a full barrel shifter in area-constrained ALU variants and sits beside the ALU, sequenced by the top-level control.

---
 rtl/shift_seq_ctrl.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/shift_seq_ctrl.sv
// shift_seq_ctrl
// Multi-cycle shift sequencer. This block stands in for a full barrel shifter
// in area-constrained ALU variants. It captures an operand, a shift amount and
// a shift type, then applies a small shift stage once per clock until the
// amount is used up. The result is presented with a one-cycle done pulse.
//
// Ports:
//   clk_i    - clock, all state changes on the rising edge
//   rst_i    - synchronous, active-high reset
//   start_i  - request, sampled only while idle
//   op_i     - 00 SLL, 01 SRL, 10 SRA, 11 reserved (pass-through)
//   data_i   - operand, captured when the request is accepted
//   shamt_i  - shift amount, captured when the request is accepted
//   busy_o   - high while an operation is in flight (SHIFT and DONE)
//   done_o   - one-cycle pulse, data_o valid
//   data_o   - result, held until the next completion or reset
//
// Build option:
//   SHIFT_STEP4_EN - when defined, the sequencer shifts by 4 per edge while at
//                    least 4 positions remain. This shortens latency. Results
//                    are identical to the 1-bit-only build.
module shift_seq_ctrl #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 5
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [1:0]       op_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic [CNT_W-1:0] shamt_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] data_o
);

    localparam logic [1:0] OP_SLL  = 2'b00;
    localparam logic [1:0] OP_SRL  = 2'b01;
    localparam logic [1:0] OP_SRA  = 2'b10;
    localparam logic [1:0] OP_PASS = 2'b11;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t           state, state_n;
    logic [WIDTH-1:0] acc, acc_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [1:0]       op_q, op_n;
    logic [WIDTH-1:0] data_n;
    logic             done_n;

    // Fill rules: SLL and SRL fill with zeros. SRA replicates the sign bit.
    // The reserved op leaves the value untouched. Its count is forced to zero
    // at acceptance, so this function is never applied to it anyway.
    function automatic logic [WIDTH-1:0] shift_by(input logic [1:0]       op,
                                                  input logic [WIDTH-1:0] v,
                                                  input int unsigned      amt);
        logic [WIDTH-1:0] r;
        case (op)
            OP_SLL:  r = v << amt;
            OP_SRL:  r = v >> amt;
            OP_SRA:  r = $unsigned($signed(v) >>> amt);
            default: r = v;
        endcase
        return r;
    endfunction

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state  <= IDLE;
            acc    <= '0;
            cnt    <= '0;
            op_q   <= OP_SLL;
            data_o <= '0;
            done_o <= 1'b0;
        end else begin
            state  <= state_n;
            acc    <= acc_n;
            cnt    <= cnt_n;
            op_q   <= op_n;
            data_o <= data_n;
            done_o <= done_n;
        end
    end

    // done_n defaults low. This makes done a single-cycle pulse, and it drops
    // on the DONE->IDLE edge.
    always_comb begin
        state_n = state;
        acc_n   = acc;
        cnt_n   = cnt;
        op_n    = op_q;
        data_n  = data_o;
        done_n  = 1'b0;

        case (state)
            IDLE: begin
                if (start_i) begin
                    acc_n   = data_i;
                    op_n    = op_i;
                    cnt_n   = (op_i == OP_PASS) ? '0 : shamt_i;
                    state_n = SHIFT;
                end
            end

            SHIFT: begin
                if (cnt == '0) begin
                    data_n  = acc;
                    done_n  = 1'b1;
                    state_n = DONE;
                end else begin
`ifdef SHIFT_STEP4_EN
                    if (cnt >= CNT_W'(4)) begin
                        acc_n = shift_by(op_q, acc, 4);
                        cnt_n = cnt - CNT_W'(4);
                    end else begin
                        acc_n = shift_by(op_q, acc, 1);
                        cnt_n = cnt - CNT_W'(1);
                    end
`else
                    acc_n = shift_by(op_q, acc, 1);
                    cnt_n = cnt - CNT_W'(1);
`endif
                end
            end

            DONE: begin
                state_n = IDLE;
            end

            default: begin
                state_n = IDLE;
            end
        endcase
    end

    assign busy_o = (state != IDLE);

endmodule
